// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register.
// Carries a control and a data bundle through STAGES register slices with a
// valid bit per slice. Supports stall, bubble insertion and flush from the
// hazard unit, and keeps a registered count of occupied slices.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 96,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned STAGES = 1,
  parameter int unsigned CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              bubble_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  occ_cnt
);

  generate
    if (STAGES < 1 || STAGES > 4 || (1 << CNT_W) <= STAGES) begin : g_bad_params
      $error("pipe_stage_reg: STAGES must be 1..4 and 2**CNT_W must exceed STAGES");
    end
  endgenerate

  logic [STAGES-1:0] vld_q, vld_d;
  logic [CTRL_W-1:0] ctrl_q [STAGES];
  logic [CTRL_W-1:0] ctrl_d [STAGES];
  logic [DATA_W-1:0] data_q [STAGES];
  logic [DATA_W-1:0] data_d [STAGES];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_vld;

  // Next-state for all slices and the occupancy counter: flush > stall > bubble > advance.
  always_comb begin
    vld_d  = vld_q;
    ctrl_d = ctrl_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    in_vld = 1'b0;
    if (flush_i) begin
      vld_d  = '0;
      ctrl_d = '{default: '0};
      data_d = '{default: '0};
      cnt_d  = '0;
    end else if (!stall_i) begin
      // A bubble is an advance whose incoming entry is forced empty.
      in_vld = valid_i & ~bubble_i;
      for (int unsigned k = 1; k < STAGES; k++) begin
        vld_d[k]  = vld_q[k-1];
        ctrl_d[k] = ctrl_q[k-1];
        data_d[k] = data_q[k-1];
      end
      // Invalid slots always carry zero control so no write enable escapes.
      vld_d[0]  = in_vld;
      ctrl_d[0] = in_vld ? ctrl_i : '0;
      data_d[0] = in_vld ? data_i : '0;
      cnt_d     = cnt_q + CNT_W'(in_vld) - CNT_W'(vld_q[STAGES-1]);
    end
  end

  // Slice and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      ctrl_q <= '{default: '0};
      data_q <= '{default: '0};
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      ctrl_q <= ctrl_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign valid_o = vld_q[STAGES-1];
  assign ctrl_o  = ctrl_q[STAGES-1];
  assign data_o  = data_q[STAGES-1];
  assign occ_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: four instances (STAGES=1..4) share one stimulus stream.
// Each instance is compared every cycle against a queue-based delay-line model;
// directed tables and sequences cover the hazard corner cases.
module tb_pipe_stage_reg;

  localparam int DW = 96;
  localparam int CW = 8;
  localparam int NW = 3;

  typedef struct packed {
    logic          v;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  typedef struct packed {
    logic          rst, stall, bubble, flush, valid;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
    logic          ev;
    logic [CW-1:0] ec;
    logic [DW-1:0] ed;
    logic [NW-1:0] eocc;
  } vec_t;

  logic clk, rst, stall_i, bubble_i, flush_i, valid_i;
  logic [CW-1:0] ctrl_i;
  logic [DW-1:0] data_i;
  logic [3:0]         vo;
  logic [3:0][CW-1:0] co;
  logic [3:0][DW-1:0] dout;
  logic [3:0][NW-1:0] occ;

  int n_checks = 0;
  int n_errors = 0;
  ent_t mq [4][$];
  vec_t tbl [$];

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dut
      pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .STAGES(g + 1), .CNT_W(NW)) u_dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .bubble_i(bubble_i), .flush_i(flush_i),
        .valid_i(valid_i), .ctrl_i(ctrl_i), .data_i(data_i),
        .valid_o(vo[g]), .ctrl_o(co[g]), .data_o(dout[g]), .occ_cnt(occ[g])
      );
    end
  endgenerate

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [CW-1:0] cd(int k);
    return 8'(8'h10 + k);
  endfunction

  function automatic logic [DW-1:0] dd(int k);
    return {32'hDA7A_0000 + 32'(k), 32'h5555_0000 + 32'(k), 32'hA5A5_0000 + 32'(k)};
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_in(logic r, logic s, logic b, logic f, logic v,
                        logic [CW-1:0] c, logic [DW-1:0] d);
    rst = r; stall_i = s; bubble_i = b; flush_i = f; valid_i = v; ctrl_i = c; data_i = d;
  endtask

  // Compare every instance against its delay-line model.
  task automatic model_check();
    for (int i = 0; i < 4; i++) begin
      ent_t e;
      int n;
      e = mq[i][mq[i].size() - 1];
      n = 0;
      for (int k = 0; k < mq[i].size(); k++) n += int'(mq[i][k].v);
      chk($sformatf("model_s%0d_valid", i + 1), 128'(vo[i]), 128'(e.v));
      chk($sformatf("model_s%0d_ctrl", i + 1), 128'(co[i]), 128'(e.c));
      chk($sformatf("model_s%0d_data", i + 1), 128'(dout[i]), 128'(e.d));
      chk($sformatf("model_s%0d_occ", i + 1), 128'(occ[i]), 128'(n));
    end
  endtask

  // Advance the model with the current inputs, clock one edge, then check.
  task automatic tick();
    for (int i = 0; i < 4; i++) begin
      ent_t e;
      if (rst || flush_i) begin
        mq[i].delete();
        for (int k = 0; k <= i; k++) mq[i].push_back('0);
      end else if (!stall_i) begin
        e = '0;
        if (!bubble_i && valid_i) e = {1'b1, ctrl_i, data_i};
        mq[i].push_front(e);
        void'(mq[i].pop_back());
      end
    end
    @(posedge clk);
    #1;
    model_check();
  endtask

  function automatic vec_t mk(logic r, logic s, logic b, logic f, logic v, int k,
                              logic ev, int ek, logic [NW-1:0] eocc);
    vec_t t;
    t.rst = r; t.stall = s; t.bubble = b; t.flush = f; t.valid = v;
    t.ctrl = (k < 0) ? 8'hFF : cd(k);
    t.data = (k < 0) ? '1 : dd(k);
    t.ev   = ev;
    t.ec   = (ek == 0) ? '0 : cd(ek);
    t.ed   = (ek == 0) ? '0 : dd(ek);
    t.eocc = eocc;
    return t;
  endfunction

  initial begin
    for (int i = 0; i < 4; i++)
      for (int k = 0; k <= i; k++) mq[i].push_back('0);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

    // Directed table for the STAGES=3 instance: stream, drain, stall, flush, stall vs bubble.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 2, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3, 1, 1, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, -1, 1, 2, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, -1, 1, 3, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, -1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 2, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3, 1, 1, 3));
    tbl.push_back(mk(0, 1, 0, 0, 1, 4, 1, 1, 3));
    tbl.push_back(mk(0, 1, 0, 0, 1, 5, 1, 1, 3));
    tbl.push_back(mk(0, 0, 0, 0, 1, 4, 1, 2, 3));
    tbl.push_back(mk(0, 1, 0, 1, 1, 5, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 2, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3, 1, 1, 3));
    tbl.push_back(mk(0, 1, 1, 0, 1, 6, 1, 1, 3));
    tbl.push_back(mk(0, 0, 1, 1, 1, 6, 0, 0, 0));

    for (int r = 0; r < tbl.size(); r++) begin
      set_in(tbl[r].rst, tbl[r].stall, tbl[r].bubble, tbl[r].flush, tbl[r].valid,
             tbl[r].ctrl, tbl[r].data);
      tick();
      chk($sformatf("tbl%0d_valid", r), 128'(vo[2]), 128'(tbl[r].ev));
      chk($sformatf("tbl%0d_ctrl", r), 128'(co[2]), 128'(tbl[r].ec));
      chk($sformatf("tbl%0d_data", r), 128'(dout[2]), 128'(tbl[r].ed));
      chk($sformatf("tbl%0d_occ", r), 128'(occ[2]), 128'(tbl[r].eocc));
    end

    // STAGES=1 as a plain stage register.
    set_in(1, 0, 0, 0, 0, '0, '0); tick();
    chk("s1_reset_valid", 128'(vo[0]), 128'(0));
    chk("s1_reset_occ", 128'(occ[0]), 128'(0));
    set_in(0, 0, 0, 0, 1, 8'hA5, 96'h1234); tick();
    chk("s1_valid", 128'(vo[0]), 128'(1));
    chk("s1_ctrl", 128'(co[0]), 128'(8'hA5));
    chk("s1_data", 128'(dout[0]), 128'(96'h1234));
    chk("s1_occ", 128'(occ[0]), 128'(1));

    // STAGES=2 bubble: D1 moves on, slice 0 empties.
    set_in(1, 0, 0, 0, 0, '0, '0); tick();
    set_in(0, 0, 0, 0, 1, cd(1), dd(1)); tick();
    chk("s2_fill_valid", 128'(vo[1]), 128'(0));
    chk("s2_fill_occ", 128'(occ[1]), 128'(1));
    set_in(0, 0, 1, 0, 1, cd(2), dd(2)); tick();
    chk("s2_bub_valid", 128'(vo[1]), 128'(1));
    chk("s2_bub_ctrl", 128'(co[1]), 128'(cd(1)));
    chk("s2_bub_occ", 128'(occ[1]), 128'(1));
    set_in(0, 0, 0, 0, 0, 8'hFF, '1); tick();
    chk("s2_after_valid", 128'(vo[1]), 128'(0));
    chk("s2_after_ctrl", 128'(co[1]), 128'(0));
    chk("s2_after_occ", 128'(occ[1]), 128'(0));

    // Reset is synchronous: no effect between edges, clears on the edge.
    set_in(1, 0, 0, 0, 0, '0, '0); tick();
    for (int k = 1; k <= 3; k++) begin
      set_in(0, 0, 0, 0, 1, cd(k), dd(k)); tick();
    end
    set_in(1, 0, 0, 0, 1, cd(4), dd(4));
    #2;
    chk("rst_noasync_valid", 128'(vo[2]), 128'(1));
    chk("rst_noasync_ctrl", 128'(co[2]), 128'(cd(1)));
    chk("rst_noasync_occ", 128'(occ[2]), 128'(3));
    tick();
    chk("rst_edge_valid", 128'(vo[2]), 128'(0));
    chk("rst_edge_data", 128'(dout[2]), 128'(0));
    chk("rst_edge_occ", 128'(occ[2]), 128'(0));
    chk("rst_edge_occ_s4", 128'(occ[3]), 128'(0));
    set_in(0, 0, 0, 0, 1, cd(5), dd(5));
    #2;
    chk("rst_release_occ", 128'(occ[2]), 128'(0));
    chk("rst_release_valid_s1", 128'(vo[0]), 128'(0));
    tick();
    chk("rst_release_edge_s1", 128'(co[0]), 128'(cd(5)));

    // Randomized hazards against the model.
    for (int n = 0; n < 600; n++) begin
      set_in(($urandom_range(0, 59) == 0), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 9) < 7), 8'($urandom),
             {32'($urandom), 32'($urandom), 32'($urandom)});
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register for the five-stage core. It carries a control bundle and a data bundle through STAGES register slices, with a valid bit per slice. It supports hazard-unit stall, bubble insertion and flush. It replaces the fixed-width hand-written stage registers: with STAGES=1 and all hazard inputs low it behaves as a plain stage register.

Parameters:
DATA_W, 96, width of data bundle (e.g. ALU result, memory read data, PC concatenated).
CTRL_W, 8, width of control bundle (e.g. reg-write, mem-to-reg, write-PC, dest reg).
STAGES, 1, number of register slices, legal range 1..4; end-to-end latency in cycles.
CNT_W, 3, width of occ_cnt; must satisfy 2^CNT_W > STAGES.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
stall_i  in  1  hold all slices
bubble_i  in  1  insert empty entry at slice 0; downstream slices advance
flush_i  in  1  squash all slices
valid_i  in  1  upstream entry valid
ctrl_i  in  CTRL_W  upstream control bundle
data_i  in  DATA_W  upstream data bundle
valid_o  out  1  valid of last slice
ctrl_o  out  CTRL_W  control of last slice
data_o  out  DATA_W  data of last slice
occ_cnt  out  CNT_W  number of slices currently holding valid entries

Behaviour:
- Reset: rst is sampled on the rising edge of clk only; there is no asynchronous path. At reset every slice gets valid=0, ctrl=0, data=0, so valid_o=0, ctrl_o=0, data_o=0 and occ_cnt=0.
- Per-edge priority is rst > flush_i > stall_i > bubble_i > normal advance.
- flush_i: every slice loads valid=0, ctrl=0, data=0 on the next edge, and occ_cnt becomes 0. A flush overrides a simultaneous stall_i or bubble_i. The entry presented on the inputs in that cycle is discarded.
- stall_i (no flush): every slice holds its valid, ctrl and data, and occ_cnt is unchanged. The input entry is not captured; upstream must also hold.
- bubble_i (no flush, no stall): slice 0 loads valid=0, ctrl=0, data=0, and slice k loads slice k-1 for k=1..STAGES-1. The input entry is not captured.
- Normal advance: slice 0 loads {valid_i, ctrl_i, data_i}, and slice k loads slice k-1.
- Invalid-input rule: in normal advance with valid_i=0, slice 0 stores ctrl=0 and data=0 regardless of ctrl_i and data_i. This guarantees that no write enable leaves on an invalid slot.
- Latency: an entry accepted at edge n appears on the outputs after edge n+STAGES-1, assuming no stall.
  - STAGES=1: outputs change on the same edge that captures the inputs.
  - Each stalled cycle adds one cycle of latency.
- Outputs are driven directly from the last slice's registers; there is no combinational path from any input to any output.
- occ_cnt is a registered counter, not a recount.
  - Next value = current + (incoming valid) - (valid leaving the last slice).
  - Incoming valid is valid_i on advance, 0 on bubble.
  - On stall the count is unchanged; on flush or rst it becomes 0.
  - occ_cnt must always equal the popcount of the slice valid bits; the bench checks this every cycle.
  - occ_cnt ranges from 0 to STAGES; it never wraps.
- Parameter checks: elaboration fails if STAGES<1, STAGES>4, or 2^CNT_W <= STAGES.

Test Plan:
1. STAGES=1: apply rst, then valid_i=1, ctrl_i=8'hA5, data_i=96'h1234 for one edge -> next cycle valid_o=1, ctrl_o=A5, data_o=1234, occ_cnt=1; no stall/bubble/flush ever asserted.
2. STAGES=3: stream entries D1,D2,D3 on consecutive edges -> D1 appears after the 3rd edge; occ_cnt reads 1,2,3; with valid_i=0 afterwards, occ_cnt drains 3,2,1,0 and ctrl_o=0 on drained slots.
3. STAGES=3 full with D1..D3, hold stall_i=1 for 2 cycles while changing inputs -> outputs hold D1, occ_cnt stays 3; after release, D2 appears on the next edge.
4. STAGES=2: bubble_i=1 for one edge with D1 in slice 0 -> slice 0 becomes invalid with ctrl=0, D1 moves to slice 1 and valid_o=1; next edge valid_o=0 and ctrl_o=0.
5. STAGES=3 full, assert flush_i and stall_i together -> next edge all valid=0, ctrl=0, data=0 and occ_cnt=0. With bubble_i and stall_i together, stall wins and all slices hold.
6. rst asserted for one edge while 2 valid entries are in flight and valid_i=1 -> outputs and occ_cnt are 0 after that edge. Deassert rst between edges with no clock -> no output change until the next edge.
